// File: rtl/unary_op_pkg.sv
// Shared opcode encoding and the unary-operator evaluation function used by unary_op_pipe.
package unary_op_pkg;

    typedef enum logic [3:0] {
        OP_NOT   = 4'd0,
        OP_POS   = 4'd1,
        OP_NEG   = 4'd2,
        OP_RAND  = 4'd3,
        OP_ROR   = 4'd4,
        OP_RXOR  = 4'd5,
        OP_RXNOR = 4'd6,
        OP_BOOL  = 4'd7,
        OP_LNOT  = 4'd8
    } op_e;

    // Widest operand/result the evaluation function can handle.
    localparam int MAX_W = 64;
    typedef logic [MAX_W-1:0] word_t;

    function automatic logic op_is_legal(input logic [3:0] op);
        return op <= 4'd8;
    endfunction

    // Widths are passed in so one function serves every instance; callers pass
    // constants, so the loops fold down to plain wiring and reduction trees.
    function automatic word_t unary_eval(input logic [3:0] op, input logic sgn,
                                         input word_t a, input int in_w, input int out_w);
        word_t ext;
        word_t mask;
        word_t res;
        logic  r_and;
        logic  r_or;
        logic  r_xor;
        ext   = '0;
        mask  = '0;
        res   = '0;
        r_and = 1'b1;
        r_or  = 1'b0;
        r_xor = 1'b0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < in_w) begin
                ext[i] = a[i];
                r_and  = r_and & a[i];
                r_or   = r_or | a[i];
                r_xor  = r_xor ^ a[i];
            end else begin
                ext[i] = sgn & a[in_w-1];
            end
            if (i < out_w) mask[i] = 1'b1;
        end
        case (op_e'(op))
            OP_NOT:   res = ~ext & mask;
            OP_POS:   res = ext & mask;
            OP_NEG:   res = (~ext + word_t'(1)) & mask;
            OP_RAND:  res[0] = r_and;
            OP_ROR:   res[0] = r_or;
            OP_RXOR:  res[0] = r_xor;
            OP_RXNOR: res[0] = ~r_xor;
            OP_BOOL:  res[0] = r_or;
            OP_LNOT:  res[0] = ~r_or;
            default:  res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/unary_op_pipe_stage.sv
// Generic one-entry valid/ready register slice; a beat moves in whenever the slot is
// empty or being drained in the same cycle.
module unary_op_pipe_stage
    import unary_op_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    // Handshake: a beat transfers on valid && ready; the sender keeps data stable
    // while valid && !ready, and this slice holds out_data stable the same way.
    logic         valid_q;
    logic         valid_d;
    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    always_comb begin
        in_ready = !valid_q || out_ready;
        valid_d  = valid_q;
        data_d   = data_q;
        if (in_ready) begin
            valid_d = in_valid;
            if (in_valid) data_d = in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/unary_op_pipe.sv
// Two-stage pipelined unary-operator engine with valid/ready streaming I/O.
// Optional UNARY_OP_PIPE_STATS_EN adds stat_cnt, a saturating count of output handshakes.
module unary_op_pipe
    import unary_op_pkg::*;
#(
    parameter int IN_W  = 4,
    parameter int OUT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic             in_signed,
    input  logic [IN_W-1:0]  in_a,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_res,
    output logic [3:0]       out_op,
    output logic             err
`ifdef UNARY_OP_PIPE_STATS_EN
    ,
    output logic [15:0]      stat_cnt
`endif
);

    localparam int S1_W = 5 + IN_W;
    localparam int S2_W = 4 + OUT_W;

    logic             s1_valid;
    logic             s2_in_ready;
    logic [S1_W-1:0]  s1_data;
    logic [3:0]       s1_op;
    logic             s1_sgn;
    logic [IN_W-1:0]  s1_a;
    logic [OUT_W-1:0] s1_res;
    logic [S2_W-1:0]  s2_data;
    word_t            a_wide;
    word_t            eval_w;
    logic             err_q;
    logic             err_d;

    unary_op_pipe_stage #(.W(S1_W)) u_s1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({in_op, in_signed, in_a}),
        .out_valid (s1_valid),
        .out_ready (s2_in_ready),
        .out_data  (s1_data)
    );

    assign {s1_op, s1_sgn, s1_a} = s1_data;

    always_comb begin
        a_wide             = '0;
        a_wide[IN_W-1:0]   = s1_a;
        eval_w             = unary_eval(s1_op, s1_sgn, a_wide, IN_W, OUT_W);
        s1_res             = eval_w[OUT_W-1:0];
    end

    generate
        if (OUT_W < MAX_W) begin : g_eval_hi
            logic unused_eval_hi;
            assign unused_eval_hi = ^eval_w[MAX_W-1:OUT_W];
        end
    endgenerate

    unary_op_pipe_stage #(.W(S2_W)) u_s2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s1_valid),
        .in_ready  (s2_in_ready),
        .in_data   ({s1_op, s1_res}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (s2_data)
    );

    assign {out_op, out_res} = s2_data;

    // err latches when an illegal beat moves from s1 into s2.
    always_comb begin
        err_d = err_q | (s1_valid && s2_in_ready && !op_is_legal(s1_op));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign err = err_q;

`ifdef UNARY_OP_PIPE_STATS_EN
    logic [15:0] stat_q;
    logic [15:0] stat_d;

    always_comb begin
        stat_d = stat_q;
        if (out_valid && out_ready && stat_q != 16'hFFFF) stat_d = stat_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stat_q <= '0;
        else        stat_q <= stat_d;
    end

    assign stat_cnt = stat_q;
`endif

endmodule

// File: tb/tb_unary_op_pipe.sv
// Self-checking bench for unary_op_pipe (IN_W=4, OUT_W=6) with a behavioural reference model.
module tb_unary_op_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_op;
    logic       in_signed;
    logic [3:0] in_a;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] out_res;
    logic [3:0] out_op;
    logic       err;
`ifdef UNARY_OP_PIPE_STATS_EN
    logic [15:0] stat_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int n_fires = 0;

    logic       s_acc;
    logic       s_fire;
    logic       s_in_ready;
    logic [5:0] s_res;
    logic [3:0] s_op;
    logic [9:0] exp_q[$];

    unary_op_pipe #(.IN_W(4), .OUT_W(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_signed (in_signed),
        .in_a      (in_a),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_op    (out_op),
        .err       (err)
`ifdef UNARY_OP_PIPE_STATS_EN
        ,
        .stat_cnt  (stat_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference: operand as an integer, results by plain arithmetic and bit counting.
    function automatic logic [5:0] model(input logic [3:0] op, input logic sgn, input logic [3:0] a);
        int v;
        int ones;
        v    = (sgn && a[3]) ? int'(a) - 16 : int'(a);
        ones = $countones(a);
        case (op)
            4'd0:    model = 6'(-v - 1);
            4'd1:    model = 6'(v);
            4'd2:    model = 6'(-v);
            4'd3:    model = {5'b0, ones == 4};
            4'd4:    model = {5'b0, ones != 0};
            4'd5:    model = {5'b0, (ones % 2) == 1};
            4'd6:    model = {5'b0, (ones % 2) == 0};
            4'd7:    model = {5'b0, ones > 0};
            4'd8:    model = {5'b0, ones == 0};
            default: model = 6'd0;
        endcase
    endfunction

    // Samples both handshakes on the falling edge, then moves just past the next rising edge.
    task automatic tick();
        @(negedge clk);
        s_acc      = in_valid && in_ready;
        s_fire     = out_valid && out_ready;
        s_in_ready = in_ready;
        s_res      = out_res;
        s_op       = out_op;
        if (s_fire) n_fires++;
        @(posedge clk);
        #1;
    endtask

    task automatic send_one(input logic [3:0] op, input logic sgn, input logic [3:0] a,
                            output logic [5:0] r, output logic [3:0] o, output int lat);
        bit accepted;
        accepted  = 0;
        lat       = -1;
        r         = '0;
        o         = '0;
        in_valid  = 1'b1;
        in_op     = op;
        in_signed = sgn;
        in_a      = a;
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (s_acc) begin
                accepted = 1;
                break;
            end
        end
        in_valid = 1'b0;
        if (accepted) begin
            for (int k = 1; k <= 10; k++) begin
                tick();
                if (s_fire) begin
                    lat = k;
                    r   = s_res;
                    o   = s_op;
                    break;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = '0;
        in_signed = 1'b0;
        in_a      = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if ({out_valid, out_res, out_op, err} !== 12'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 000", {out_valid, out_res, out_op, err});
        end
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_not();
        logic [5:0] r;
        logic [3:0] o;
        int lat;
        send_one(4'd0, 1'b0, 4'b0101, r, o, lat);
        n_tests++;
        if (r !== 6'b111010 || o !== 4'd0) begin
            n_fail++;
            $display("FAIL not_result: got res=%b op=%0d expected res=111010 op=0", r, o);
        end
        n_tests++;
        if (lat !== 2) begin
            n_fail++;
            $display("FAIL not_latency: got %0d expected 2", lat);
        end
    endtask

    task automatic test_neg_pos();
        logic [5:0] r;
        logic [3:0] o;
        int lat;
        send_one(4'd2, 1'b1, 4'b1000, r, o, lat);
        n_tests++;
        if (r !== 6'b001000 || lat !== 2) begin
            n_fail++;
            $display("FAIL neg_signed: got %b lat=%0d expected 001000 lat=2", r, lat);
        end
        send_one(4'd2, 1'b0, 4'b1000, r, o, lat);
        n_tests++;
        if (r !== 6'b111000 || lat !== 2) begin
            n_fail++;
            $display("FAIL neg_unsigned: got %b lat=%0d expected 111000 lat=2", r, lat);
        end
        send_one(4'd1, 1'b1, 4'b1010, r, o, lat);
        n_tests++;
        if (r !== 6'b111010 || o !== 4'd1) begin
            n_fail++;
            $display("FAIL pos_signed: got %b op=%0d expected 111010 op=1", r, o);
        end
    endtask

    task automatic test_reductions();
        logic [5:0] r;
        logic [3:0] o;
        int lat;
        logic [5:0] exp_tab [6];
        exp_tab = '{6'd0, 6'd1, 6'd1, 6'd0, 6'd1, 6'd0};
        for (int i = 0; i < 6; i++) begin
            send_one(4'(3 + i), 1'($urandom_range(0, 1)), 4'b0111, r, o, lat);
            n_tests++;
            if (r !== exp_tab[i] || o !== 4'(3 + i)) begin
                n_fail++;
                $display("FAIL reduce_op%0d: got %b op=%0d expected %b", 3 + i, r, o, exp_tab[i]);
            end
        end
        send_one(4'd8, 1'b0, 4'b0000, r, o, lat);
        n_tests++;
        if (r !== 6'b000001) begin
            n_fail++;
            $display("FAIL lnot_zero: got %b expected 000001", r);
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] b_op [3];
        logic [3:0] b_a  [3];
        logic       b_s  [3];
        int idx;
        int got;
        int last;
        int first;
        bit gap_bad;
        logic [9:0] e;
        for (int i = 0; i < 3; i++) begin
            b_op[i] = 4'($urandom_range(0, 8));
            b_a[i]  = 4'($urandom);
            b_s[i]  = 1'($urandom_range(0, 1));
        end
        idx       = 0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op     = b_op[0];
        in_a      = b_a[0];
        in_signed = b_s[0];
        for (int c = 0; c < 6; c++) begin
            tick();
            if (s_acc && idx < 3) begin
                exp_q.push_back({b_op[idx], model(b_op[idx], b_s[idx], b_a[idx])});
                idx++;
                if (idx < 3) begin
                    in_op     = b_op[idx];
                    in_a      = b_a[idx];
                    in_signed = b_s[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        n_tests++;
        if (idx !== 2 || s_in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_fill: got accepted=%0d in_ready=%b expected accepted=2 in_ready=0", idx, s_in_ready);
        end
        out_ready = 1'b1;
        got     = 0;
        last    = -1;
        first   = -1;
        gap_bad = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (s_acc && idx < 3) begin
                exp_q.push_back({b_op[idx], model(b_op[idx], b_s[idx], b_a[idx])});
                idx++;
                in_valid = 1'b0;
            end
            if (s_fire) begin
                if (first < 0) first = c;
                if (last >= 0 && c != last + 1) gap_bad = 1;
                last = c;
                got++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3FF;
                n_tests++;
                if ({s_op, s_res} !== e) begin
                    n_fail++;
                    $display("FAIL bp_order: got op=%0d res=%b expected op=%0d res=%b", s_op, s_res, e[9:6], e[5:0]);
                end
            end
            if (got == 3) break;
        end
        in_valid = 1'b0;
        n_tests++;
        if (got !== 3 || gap_bad || first !== 0) begin
            n_fail++;
            $display("FAIL bp_drain: got count=%0d first=%0d gap=%0d expected count=3 first=0 gap=0", got, first, gap_bad);
        end
    endtask

    task automatic test_illegal();
        logic [5:0] r;
        logic [3:0] o;
        int lat;
        send_one(4'hF, 1'b0, 4'h3, r, o, lat);
        n_tests++;
        if (r !== 6'd0 || o !== 4'hF || err !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_op: got res=%b op=%h err=%b expected res=000000 op=f err=1", r, o, err);
        end
        send_one(4'd0, 1'b0, 4'b0101, r, o, lat);
        n_tests++;
        if (err !== 1'b1 || r !== 6'b111010) begin
            n_fail++;
            $display("FAIL err_sticky: got err=%b res=%b expected err=1 res=111010", err, r);
        end
    endtask

    task automatic test_random();
        logic [9:0] e;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 400; c++) begin
            tick();
            if (s_acc) exp_q.push_back({in_op, model(in_op, in_signed, in_a)});
            if (s_fire) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3FF;
                n_tests++;
                if ({s_op, s_res} !== e) begin
                    n_fail++;
                    $display("FAIL rand_beat: got op=%0d res=%b expected op=%0d res=%b", s_op, s_res, e[9:6], e[5:0]);
                end
            end
            if (!in_valid || s_acc) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                in_op     = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
                in_signed = 1'($urandom_range(0, 1));
                in_a      = 4'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
            tick();
            if (s_fire) begin
                e = exp_q.pop_front();
                n_tests++;
                if ({s_op, s_res} !== e) begin
                    n_fail++;
                    $display("FAIL rand_drain: got op=%0d res=%b expected op=%0d res=%b", s_op, s_res, e[9:6], e[5:0]);
                end
            end
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rand_leftover: got %0d pending expected 0", exp_q.size());
        end
`ifdef UNARY_OP_PIPE_STATS_EN
        n_tests++;
        if (stat_cnt !== 16'(n_fires)) begin
            n_fail++;
            $display("FAIL stat_cnt: got %0d expected %0d", stat_cnt, n_fires);
        end
`endif
    endtask

    task automatic test_reset_midstream();
        int acc;
        int fires;
        acc       = 0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op     = 4'd1;
        in_signed = 1'b0;
        in_a      = 4'h5;
        for (int c = 0; c < 10 && acc < 2; c++) begin
            tick();
            if (s_acc) begin
                acc++;
                in_a = 4'h6;
            end
        end
        in_valid = 1'b0;
        n_tests++;
        if (acc !== 2 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_fill: got accepted=%0d out_valid=%b expected 2 and 1", acc, out_valid);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({out_valid, out_res, out_op, err} !== 12'd0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got %h expected 000", {out_valid, out_res, out_op, err});
        end
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        n_fires   = 0;
        fires     = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (s_fire) fires++;
        end
        n_tests++;
        if (fires !== 0) begin
            n_fail++;
            $display("FAIL mid_no_emit: got %0d outputs expected 0", fires);
        end
`ifdef UNARY_OP_PIPE_STATS_EN
        n_tests++;
        if (stat_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL mid_stat_cnt: got %0d expected 0", stat_cnt);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_not();
        test_neg_pos();
        test_reductions();
        test_backpressure();
        test_illegal();
        test_random();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
